// File: rtl/result_drain.sv
// Purpose: captures one row of ARR_SIZE 16-bit lanes and drains it as 32-bit lane pairs.
// Latency: the first word is valid the cycle after capture, then one word per cycle.
// Backpressure: out_ready low freezes the word. cap_ready opens only when idle or on the last word's acceptance.
module result_drain #(
    parameter int ARR_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ARR_SIZE*16-1:0]  row_in,
    input  logic                    cap_valid,
    output logic                    cap_ready,
    output logic [31:0]             data_out,
    output logic [6:0]              addr_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              rows_done
);

    localparam int NW    = (ARR_SIZE + 1) / 2;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ARR_SIZE*16-1:0]  row_q, row_d;
    logic [7:0]              rows_done_q, rows_done_d;

    // Word view of the row, zero-padded so an odd lane count ends with a zero high half.
    logic [NW*32-1:0]        row_ext;
    logic                    last_word;

    // Pad the captured row up to a whole number of 32-bit words.
    always_comb begin
        row_ext = '0;
        row_ext[ARR_SIZE*16-1:0] = row_q;
    end

    assign last_word = (idx_q == LAST_IDX);
    assign rows_done = rows_done_q;

    // Next-state and output decode. Outputs depend only on registered state,
    // except cap_ready, which opens on the final word's acceptance.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        row_d       = row_q;
        rows_done_d = rows_done_q;
        cap_ready   = 1'b0;
        out_valid   = 1'b0;
        data_out    = '0;
        addr_out    = '0;
        case (state_q)
            IDLE: begin
                cap_ready = 1'b1;
                if (cap_valid) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                    row_d   = row_in;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                data_out  = row_ext[32*idx_q +: 32];
                addr_out  = 7'({idx_q, 1'b0});
                if (out_ready) begin
                    if (last_word) begin
                        // The row completes here. A waiting row is taken on the same
                        // edge, so back-to-back rows have no bubble.
                        cap_ready   = 1'b1;
                        rows_done_d = rows_done_q + 8'd1;
                        idx_d       = '0;
                        if (cap_valid) begin
                            row_d = row_in;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. The asynchronous clear also discards any partly drained row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            row_q       <= '0;
            rows_done_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            rows_done_q <= rows_done_d;
        end
    end

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter ARR_SIZE, default 4, giving the number of 16-bit lanes per captured row; legal range 2..64, odd values allowed.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port row_in  input  ARR_SIZE*16  row of lanes; lane i occupies bits [(i+1)*16-1 : i*16].
REQ-005 SHALL have port cap_valid  input  1  row_in holds a row to capture.
REQ-006 SHALL have port cap_ready  output  1  block can accept a row this cycle.
REQ-007 SHALL have port data_out  output  32  word being emitted.
REQ-008 SHALL have port addr_out  output  7  lane index of data_out[15:0].
REQ-009 SHALL have port out_valid  output  1  data_out/addr_out hold a valid word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the word this cycle.
REQ-011 SHALL have port rows_done  output  8  count of fully drained rows, wraps 255->0.

Function
REQ-012 SHALL serialize each captured row into NW = ceil(ARR_SIZE/2) words, word k carrying lane 2k in data_out[15:0] and lane 2k+1 in data_out[31:16], with addr_out = 2k; the pairing is addr i -> low half, i+1 -> high half.
REQ-013 SHALL drive data_out[31:16] = 0 for the last word when ARR_SIZE is odd.
REQ-014 SHALL capture row_in into an internal row register on a clock edge where cap_valid && cap_ready (capture handshake).
REQ-015 SHALL implement a state machine with states IDLE and DRAIN; IDLE -> DRAIN on a capture; DRAIN -> IDLE on acceptance of word NW-1 with no simultaneous capture; DRAIN -> DRAIN with word index 0 on acceptance of word NW-1 with simultaneous capture.
REQ-016 SHALL assert cap_ready combinationally when state is IDLE, or when state is DRAIN && word index == NW-1 && out_ready; otherwise deasserted.
REQ-017 SHALL assert out_valid exactly when state is DRAIN; first word is valid in the cycle after the capture edge (latency 1 cycle).
REQ-018 SHALL advance the word index by 1 on each edge with out_valid && out_ready, and hold data_out, addr_out and the index stable while out_valid && !out_ready.
REQ-019 SHALL derive data_out/addr_out from registered state only (no combinational path from row_in or out_ready to data_out/addr_out).
REQ-020 SHALL ignore row_in and cap_valid whenever cap_ready is low; no row is lost or partially overwritten.
REQ-021 SHALL increment rows_done by 1 on each acceptance of word NW-1, including back-to-back rows.
REQ-022 SHALL sustain one word per cycle with continuous out_ready and cap_valid; no bubble between rows.
REQ-023 SHALL drive data_out to 0 and addr_out to 0 while out_valid is low.

Reset
REQ-024 SHALL, while rst is low, force state IDLE, word index 0, row register 0, rows_done 0, out_valid 0, data_out 0, addr_out 0, asynchronously without waiting for clk.
REQ-025 SHALL discard any partially drained row when rst is asserted mid-DRAIN; no word of it reappears after release.
REQ-026 SHALL assert cap_ready in the first cycle after rst deasserts.

Verification
REQ-027 Single row, ARR_SIZE=4, lanes {0x0004,0x0003,0x0002,0x0001} (lane3..lane0), out_ready=1 -> words 0x00020001 @addr 0, 0x00040003 @addr 2 on consecutive cycles starting 1 cycle after capture; rows_done=1; out_valid low after.
REQ-028 Backpressure: out_ready=0 for 3 cycles during word 0 -> data_out=0x00020001, addr_out=0 held stable, cap_ready=0, new cap_valid ignored; resumes on out_ready=1.
REQ-029 Back-to-back: two rows offered continuously with out_ready=1 -> 4 words on 4 consecutive cycles, second row captured on the same edge as acceptance of word 1 of the first, rows_done=2.
REQ-030 Odd size, ARR_SIZE=5, lane4=0xBEEF -> 3 words; last word data_out=0x0000BEEF, addr_out=4.
REQ-031 Reset mid-drain: rst low after word 0 accepted -> out_valid, data_out, rows_done immediately 0; after release cap_ready=1, no stale word emitted.
REQ-032 Counter wrap: drain 256 rows -> rows_done returns to 0.
